// File: rtl/tick_task_scheduler.sv
// Periodic task sequencer: per-slot tick period counters raise pending flags.
// A round-robin req/ack dispatcher serves them, abandoning a grant after an ack timeout.
module tick_task_slot #(
   parameter int PERIOD_W = 10
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                tick_en,
   input  logic                cfg_hit,
   input  logic [PERIOD_W-1:0] cfg_period,
   input  logic                granted,
   input  logic                srv_clr,
   input  logic                err_clr,
   output logic                pending,
   output logic                overrun
);
   logic [PERIOD_W-1:0] period_q, period_d, cnt_q, cnt_d;
   logic                pending_q, pending_d, overrun_q, overrun_d;
   logic                due, clr;

   always_comb begin
      period_d = period_q;
      cnt_d    = cnt_q;
      due      = 1'b0;
      if (cfg_hit) begin
         period_d = cfg_period;
         cnt_d    = cfg_period;
      end else if (tick_en && period_q != '0) begin
         if (cnt_q <= PERIOD_W'(1)) begin
            due   = 1'b1;
            cnt_d = period_q;
         end else begin
            cnt_d = cnt_q - PERIOD_W'(1);
         end
      end
      // A config write drops a queued request, but never one already in service.
      clr       = srv_clr | (cfg_hit & ~granted);
      pending_d = (pending_q & ~clr) | due;
      overrun_d = (due & pending_q & ~clr) | (overrun_q & ~err_clr);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         period_q  <= '0;
         cnt_q     <= '0;
         pending_q <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         period_q  <= period_d;
         cnt_q     <= cnt_d;
         pending_q <= pending_d;
         overrun_q <= overrun_d;
      end
   end

   assign pending = pending_q;
   assign overrun = overrun_q;
endmodule

module tick_task_scheduler #(
   parameter int NUM_TASKS = 4,
   parameter int PERIOD_W  = 10,
   parameter int TIMEOUT   = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         tick_in,
   input  logic                         enable,
   input  logic                         cfg_we,
   input  logic [$clog2(NUM_TASKS)-1:0] cfg_idx,
   input  logic [PERIOD_W-1:0]          cfg_period,
   input  logic [NUM_TASKS-1:0]         task_ack,
   output logic [NUM_TASKS-1:0]         task_req,
   output logic [NUM_TASKS-1:0]         pending,
   output logic [NUM_TASKS-1:0]         overrun,
   output logic                         timeout_err,
   input  logic                         err_clr,
   output logic                         busy
);
   localparam int IDX_W = $clog2(NUM_TASKS);
   localparam int TMO_W = $clog2(TIMEOUT + 1);

   typedef enum logic {IDLE, GRANT} state_e;

   state_e               state_q, state_d;
   logic [IDX_W-1:0]     g_q, g_d, ptr_q, ptr_d, sel;
   logic [TMO_W-1:0]     tmo_q, tmo_d;
   logic                 timeout_err_q, timeout_err_d, tmo_fire, found;
   logic [NUM_TASKS-1:0] cfg_hit, srv_clr;
   int                   idx;

   always_comb begin
      for (int i = 0; i < NUM_TASKS; i++)
         cfg_hit[i] = cfg_we && (int'(cfg_idx) == i);
   end

   for (genvar i = 0; i < NUM_TASKS; i++) begin : g_slot
      tick_task_slot #(.PERIOD_W(PERIOD_W)) u_slot (
         .clk       (clk),
         .rst       (rst),
         .tick_en   (tick_in & enable),
         .cfg_hit   (cfg_hit[i]),
         .cfg_period(cfg_period),
         .granted   (task_req[i]),
         .srv_clr   (srv_clr[i]),
         .err_clr   (err_clr),
         .pending   (pending[i]),
         .overrun   (overrun[i])
      );
   end

   // First pending slot at or after ptr, wrapping.
   always_comb begin
      sel   = ptr_q;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < NUM_TASKS; k++) begin
         idx = (int'(ptr_q) + k) % NUM_TASKS;
         if (!found && pending[idx]) begin
            found = 1'b1;
            sel   = IDX_W'(idx);
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      g_d      = g_q;
      ptr_d    = ptr_q;
      tmo_d    = tmo_q;
      srv_clr  = '0;
      tmo_fire = 1'b0;
      case (state_q)
         IDLE: begin
            tmo_d = '0;
            if (found) begin
               state_d = GRANT;
               g_d     = sel;
            end
         end
         GRANT: begin
            if (task_ack[g_q] || tmo_q == TMO_W'(TIMEOUT - 1)) begin
               srv_clr[g_q] = 1'b1;
               tmo_fire     = !task_ack[g_q];
               ptr_d        = IDX_W'((int'(g_q) + 1) % NUM_TASKS);
               state_d      = IDLE;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      timeout_err_d = tmo_fire | (timeout_err_q & ~err_clr);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         g_q           <= '0;
         ptr_q         <= '0;
         tmo_q         <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         g_q           <= g_d;
         ptr_q         <= ptr_d;
         tmo_q         <= tmo_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   // Decoded from the async-reset state, so reset drops the request without a clock.
   always_comb begin
      task_req = '0;
      if (state_q == GRANT) task_req[g_q] = 1'b1;
   end

   assign busy        = (state_q == GRANT);
   assign timeout_err = timeout_err_q;
endmodule

// File: tb/tb_tick_task_scheduler.sv
// Directed bench for tick_task_scheduler: hand-computed expectations per step.
module tb_tick_task_scheduler;
   logic       clk, rst, tick_in, enable, cfg_we, err_clr, timeout_err, busy;
   logic [1:0] cfg_idx;
   logic [9:0] cfg_period;
   logic [3:0] task_ack, task_req, pending, overrun;
   int         vectors = 0;
   int         miscompares = 0;

   tick_task_scheduler #(.NUM_TASKS(4), .PERIOD_W(10), .TIMEOUT(16)) dut (
      .clk(clk), .rst(rst), .tick_in(tick_in), .enable(enable), .cfg_we(cfg_we),
      .cfg_idx(cfg_idx), .cfg_period(cfg_period), .task_ack(task_ack),
      .task_req(task_req), .pending(pending), .overrun(overrun),
      .timeout_err(timeout_err), .err_clr(err_clr), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0; tick_in = 1'b0; enable = 1'b0; cfg_we = 1'b0; cfg_idx = '0;
      cfg_period = '0; task_ack = '0; err_clr = 1'b0;
      cyc(); cyc();
      rst = 1'b1;
      enable = 1'b1;
   endtask

   task automatic cfg(input logic [1:0] i, input logic [9:0] p);
      cfg_we = 1'b1; cfg_idx = i; cfg_period = p;
      cyc();
      cfg_we = 1'b0;
   endtask

   task automatic tick();
      tick_in = 1'b1;
      cyc();
      tick_in = 1'b0;
   endtask

   initial begin
      // Reset state
      do_reset();
      chk("rst_req", 32'(task_req), 32'h0);
      chk("rst_pend", 32'(pending), 32'h0);
      chk("rst_ovr", 32'(overrun), 32'h0);
      chk("rst_tmo", 32'(timeout_err), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);

      // 1: period 3, ten ticks, ack two cycles after req rises
      cfg(2'd0, 10'd3);
      for (int t = 1; t <= 10; t++) begin
         tick();
         chk("t1_pend", 32'(pending), (t % 3 == 0) ? 32'h1 : 32'h0);
         if (t % 3 == 0) begin
            cyc();
            chk("t1_req", 32'(task_req), 32'h1);
            chk("t1_busy", 32'(busy), 32'h1);
            cyc();
            chk("t1_req_hold", 32'(task_req), 32'h1);
            task_ack = 4'b0001;
            cyc();
            task_ack = '0;
            chk("t1_ack_req", 32'(task_req), 32'h0);
            chk("t1_ack_pend", 32'(pending), 32'h0);
         end else begin
            cyc(); cyc();
            chk("t1_noreq", 32'(task_req), 32'h0);
         end
      end
      chk("t1_ovr", 32'(overrun), 32'h0);

      // 2: all slots due together, immediate acks, two rounds
      do_reset();
      for (int i = 0; i < 4; i++) cfg(2'(i), 10'd1);
      for (int r = 0; r < 2; r++) begin
         tick();
         chk("t2_pend_all", 32'(pending), 32'hF);
         for (int k = 0; k < 4; k++) begin
            cyc();
            chk("t2_order", 32'(task_req), 32'(1 << k));
            task_ack = 4'(1 << k);
            cyc();
            task_ack = '0;
            chk("t2_gap", 32'(task_req), 32'h0);
            chk("t2_pend", 32'(pending), 32'hF & ~((32'h2 << k) - 1));
         end
      end
      chk("t2_ovr", 32'(overrun), 32'h0);

      // 3: never ack -> 16 cycles of req, then timeout
      do_reset();
      cfg(2'd2, 10'd2);
      tick();
      chk("t3_pend_early", 32'(pending), 32'h0);
      tick();
      chk("t3_pend", 32'(pending), 32'h4);
      cyc();
      chk("t3_req_0", 32'(task_req), 32'h4);
      for (int n = 1; n < 16; n++) begin
         cyc();
         chk("t3_req_hold", 32'(task_req), 32'h4);
      end
      chk("t3_tmo_early", 32'(timeout_err), 32'h0);
      cyc();
      chk("t3_req_drop", 32'(task_req), 32'h0);
      chk("t3_tmo", 32'(timeout_err), 32'h1);
      chk("t3_pend_clr", 32'(pending), 32'h0);
      chk("t3_busy", 32'(busy), 32'h0);
      err_clr = 1'b1;
      cyc();
      err_clr = 1'b0;
      chk("t3_errclr", 32'(timeout_err), 32'h0);

      // 4: overrun while withheld, err_clr priority, due during ack
      do_reset();
      cfg(2'd1, 10'd1);
      tick();
      chk("t4_pend", 32'(pending), 32'h2);
      cyc();
      chk("t4_req", 32'(task_req), 32'h2);
      chk("t4_ovr0", 32'(overrun), 32'h0);
      tick();
      chk("t4_ovr", 32'(overrun), 32'h2);
      chk("t4_pend_hold", 32'(pending), 32'h2);
      err_clr = 1'b1; tick_in = 1'b1;
      cyc();
      err_clr = 1'b0; tick_in = 1'b0;
      chk("t4_set_wins", 32'(overrun), 32'h2);
      err_clr = 1'b1;
      cyc();
      err_clr = 1'b0;
      chk("t4_ovr_clr", 32'(overrun), 32'h0);
      tick_in = 1'b1; task_ack = 4'b0010;
      cyc();
      tick_in = 1'b0; task_ack = '0;
      chk("t4_ackdue_pend", 32'(pending), 32'h2);
      chk("t4_ackdue_ovr", 32'(overrun), 32'h0);
      chk("t4_ackdue_req", 32'(task_req), 32'h0);
      cyc();
      chk("t4_regrant", 32'(task_req), 32'h2);

      // 5: config write beats a due tick; period 0 disables
      do_reset();
      cfg(2'd0, 10'd2);
      tick();
      cfg_we = 1'b1; cfg_idx = 2'd0; cfg_period = 10'd3; tick_in = 1'b1;
      cyc();
      cfg_we = 1'b0; tick_in = 1'b0;
      chk("t5_cfgwin_pend", 32'(pending), 32'h0);
      cyc();
      chk("t5_cfgwin_req", 32'(task_req), 32'h0);
      for (int t = 1; t <= 3; t++) begin
         tick();
         chk("t5_reload", 32'(pending), (t == 3) ? 32'h1 : 32'h0);
      end
      cyc();
      chk("t5_req", 32'(task_req), 32'h1);
      task_ack = 4'b0001;
      cyc();
      task_ack = '0;
      cfg(2'd0, 10'd0);
      for (int t = 0; t < 5; t++) begin
         tick();
         cyc();
         chk("t5_off_pend", 32'(pending), 32'h0);
         chk("t5_off_req", 32'(task_req), 32'h0);
      end

      // 6: asynchronous reset mid-grant
      do_reset();
      cfg(2'd3, 10'd1);
      tick();
      cyc();
      chk("t6_req", 32'(task_req), 32'h8);
      chk("t6_busy", 32'(busy), 32'h1);
      #2 rst = 1'b0;
      #1;
      chk("t6_async_req", 32'(task_req), 32'h0);
      chk("t6_async_pend", 32'(pending), 32'h0);
      chk("t6_async_busy", 32'(busy), 32'h0);
      cyc();
      rst = 1'b1;
      for (int t = 0; t < 3; t++) begin
         tick();
         cyc();
         chk("t6_post_req", 32'(task_req), 32'h0);
         chk("t6_post_pend", 32'(pending), 32'h0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/tick_task_scheduler.md
Name: tick_task_scheduler

Overview:
- Sequences periodic housekeeping tasks (position fix, NMEA output, status update, ...) off the 1 ms tick strobe from the prescaler chain.
- Holds a programmable period for each task slot and counts ticks per slot.
- Marks a task pending when its period expires.
- Dispatches pending tasks one at a time to their engines, using a round-robin req/ack handshake with an ack timeout.

Parameters:
- NUM_TASKS, 4, number of task slots (2..8).
- PERIOD_W, 10, width of the period and tick counters, in ticks.
- TIMEOUT, 16, clk cycles to wait for task_ack before the grant is abandoned.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset (0 = reset)
- tick_in  in  1  one-cycle strobe from the prescaler (1 per ms)
- enable  in  1  1 = period counters advance on tick_in
- cfg_we  in  1  one-cycle period write strobe
- cfg_idx  in  $clog2(NUM_TASKS)  slot written by cfg_we
- cfg_period  in  PERIOD_W  period in ticks; 0 = slot disabled
- task_ack  in  NUM_TASKS  completion pulse from the task engines
- task_req  out  NUM_TASKS  one-hot level request to the granted engine
- pending  out  NUM_TASKS  due-but-not-yet-served flags
- overrun  out  NUM_TASKS  sticky: task became due while still pending
- timeout_err  out  1  sticky: a grant timed out
- err_clr  in  1  clears overrun and timeout_err
- busy  out  1  1 while a grant is outstanding

Behaviour:
- Reset (rst=0, asynchronous):
  - period[], cnt[], pending, overrun, timeout_err, task_req and busy all go to 0.
  - Round-robin pointer goes to 0; FSM goes to IDLE.
- Config:
  - cfg_we loads period[cfg_idx]=cfg_period and cnt[cfg_idx]=cfg_period.
  - pending[cfg_idx] is cleared, unless that slot is currently granted; a grant in service is never aborted.
  - cfg_we and tick_in in the same cycle for the same slot: the config write wins and the tick is ignored for that slot.
  - cfg_idx >= NUM_TASKS: the write is ignored.
- Tick counting, per slot i, on tick_in=1 with enable=1 and period[i]!=0:
  - If cnt[i]<=1: the slot is due, and cnt[i] reloads to period[i].
  - Otherwise cnt[i] decrements.
  - Result: period P gives one due event every P ticks; the first due event is P ticks after the config write.
  - enable=0 freezes all counters; pending tasks still drain.
  - period[i]=0: cnt[i] holds and the slot is never due.
- Pending and overrun, in the cycle after the due tick:
  - A due event sets pending[i].
  - If pending[i] is already 1 and is not being cleared in the same cycle, overrun[i] is set.
  - A due event in the same cycle as an ack clear for that slot leaves pending[i]=1 and does not set overrun.
- FSM with two states, IDLE and GRANT:
  - IDLE:
    - If pending!=0, select the first set bit searching from ptr upward, wrapping modulo NUM_TASKS; call it g.
    - Go to GRANT on the next cycle with task_req=onehot(g) and busy=1.
    - The timeout counter is zeroed.
  - GRANT, ack received (task_ack[g]=1):
    - Clear pending[g], set task_req=0 and busy=0, set ptr=(g+1) mod NUM_TASKS, return to IDLE.
    - Bits of task_ack other than g are ignored.
  - GRANT, no ack:
    - The timeout counter increments each cycle.
    - When it reaches TIMEOUT-1 without ack: set timeout_err=1, clear pending[g], set ptr=g+1, drop task_req, return to IDLE.
- Timing and handshake:
  - At least one IDLE cycle separates consecutive grants.
  - Latency from pending set to task_req high is 1 cycle.
  - task_req stays high until ack or timeout.
- Errors:
  - err_clr clears all overrun bits and timeout_err.
  - A set event in the same cycle as err_clr wins.
- Reset mid-grant: task_req drops immediately (asynchronously).

Test Plan:
1. Reset, write period[0]=3, enable=1, 10 ticks, ack each request 2 cycles after task_req rises -> task_req[0] pulses after ticks 3, 6 and 9; pending[0] clears on each ack; overrun=0.
2. Periods 1/1/1/1, all slots due on the same tick, immediate acks -> grant order 0,1,2,3; after further ticks the order continues 0,1,... with the pointer advancing past each served slot.
3. period[2]=2, never ack -> task_req[2] stays high for 16 cycles, then timeout_err=1 and pending[2]=0; err_clr -> timeout_err=0.
4. period[1]=1, withhold ack across 2 ticks with TIMEOUT raised -> overrun[1]=1 on the second due event; pending[1] stays 1.
5. Assert cfg_we for slot 0 in the same cycle as tick_in where cnt[0]=1 -> no due event; cnt[0] reloads to the new period. Then write period 0 -> slot 0 is never requested.
6. Drive rst=0 mid-grant -> task_req, pending and busy go to 0 without waiting for a clock edge; after release the FSM is in IDLE and all periods read 0 (no requests issued).
